// File: rtl/lane_scatter_pkg.sv
// Shared types and lane geometry for the lane scatter block.
package lane_scatter_pkg;

    localparam int LANES  = 4;
    localparam int SEL_W  = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/lane_scatter_decode.sv
// Maps per-lane selects/enables to bank byte strobes and source lanes.
// A higher lane overwrites a lower one on the same target and flags a collision.
module lane_decode
    import lane_scatter_pkg::*;
(
    input  logic [LANES*SEL_W-1:0] i_sel,
    input  logic [LANES-1:0]       i_en,
    output logic [LANES-1:0]       o_wr_a,
    output logic [LANES-1:0]       o_wr_b,
    output logic [2*LANES-1:0]     o_src_a,
    output logic [2*LANES-1:0]     o_src_b,
    output logic                   o_collide
);

    logic [1:0] w_pos;

    always_comb begin
        o_wr_a    = '0;
        o_wr_b    = '0;
        o_src_a   = '0;
        o_src_b   = '0;
        o_collide = 1'b0;
        w_pos     = 2'd0;
        for (int i = 0; i < LANES; i++) begin
            if (i_en[i]) begin
                w_pos = i_sel[SEL_W*i +: 2];
                if (i_sel[SEL_W*i+2]) begin
                    if (o_wr_b[w_pos]) o_collide = 1'b1;
                    o_wr_b[w_pos]            = 1'b1;
                    o_src_b[2*w_pos +: 2]    = 2'(i);
                end else begin
                    if (o_wr_a[w_pos]) o_collide = 1'b1;
                    o_wr_a[w_pos]            = 1'b1;
                    o_src_a[2*w_pos +: 2]    = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/lane_scatter.sv
// Scatters input byte lanes of each beat into two bank words, emitting the frame on OUT_VALID.
//   state | meaning
//   IDLE  | no beats yet in this frame
//   ACCUM | at least one beat accepted, frame still open
//   HOLD  | frame complete, presented until OUT_READY
module lane_scatter
    import lane_scatter_pkg::*;
#(
    parameter int MAX_BEATS = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_L,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*BYTE_W-1:0] DATA_IN,
    input  logic [LANES*SEL_W-1:0] sc_sel,
    input  logic [LANES-1:0]       sc_EN,
    input  logic                   sc_LAST,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES*BYTE_W-1:0] DATA_A,
    output logic [LANES*BYTE_W-1:0] DATA_B,
    output logic [LANES-1:0]       BYTE_EN_A,
    output logic [LANES-1:0]       BYTE_EN_B,
    output logic                   ERR_COLLIDE,
    output logic                   ERR_OVF
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [LANES*BYTE_W-1:0] r_data_a, r_data_b;
    logic [LANES-1:0]        r_be_a, r_be_b;
    logic                    r_out_valid, r_err_coll, r_err_ovf;

    logic [LANES-1:0]        w_wr_a, w_wr_b;
    logic [2*LANES-1:0]      w_src_a, w_src_b;
    logic                    w_collide, w_accept, w_at_max, w_last;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [LANES*BYTE_W-1:0] w_data_a_nxt, w_data_b_nxt;

    lane_decode u_decode (
        .i_sel     (sc_sel),
        .i_en      (sc_EN),
        .o_wr_a    (w_wr_a),
        .o_wr_b    (w_wr_b),
        .o_src_a   (w_src_a),
        .o_src_b   (w_src_b),
        .o_collide (w_collide)
    );

    assign IN_READY   = (r_state != HOLD);
    assign w_accept   = IN_VALID & IN_READY;
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_at_max   = (w_cnt_next == CNT_W'(MAX_BEATS));
    assign w_last     = sc_LAST | w_at_max;

    always_comb begin
        w_data_a_nxt = r_data_a;
        w_data_b_nxt = r_data_b;
        for (int p = 0; p < LANES; p++) begin
            if (w_wr_a[p]) w_data_a_nxt[BYTE_W*p +: BYTE_W] = DATA_IN[BYTE_W*w_src_a[2*p +: 2] +: BYTE_W];
            if (w_wr_b[p]) w_data_b_nxt[BYTE_W*p +: BYTE_W] = DATA_IN[BYTE_W*w_src_b[2*p +: 2] +: BYTE_W];
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_be_a      <= '0;
            r_be_b      <= '0;
            r_out_valid <= 1'b0;
            r_err_coll  <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_err_coll <= 1'b0;
            r_err_ovf  <= 1'b0;
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_data_a   <= w_data_a_nxt;
                        r_data_b   <= w_data_b_nxt;
                        r_be_a     <= r_be_a | w_wr_a;
                        r_be_b     <= r_be_b | w_wr_b;
                        r_cnt      <= w_cnt_next;
                        r_err_coll <= w_collide;
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_err_ovf   <= w_at_max & ~sc_LAST;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_data_a    <= '0;
                        r_data_b    <= '0;
                        r_be_a      <= '0;
                        r_be_b      <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign OUT_VALID   = r_out_valid;
    assign DATA_A      = r_data_a;
    assign DATA_B      = r_data_b;
    assign BYTE_EN_A   = r_be_a;
    assign BYTE_EN_B   = r_be_b;
    assign ERR_COLLIDE = r_err_coll;
    assign ERR_OVF     = r_err_ovf;

endmodule

// File: doc/lane_scatter.md
LANE_SCATTER -- requirements
Module: lane_scatter

Interface
REQ-001 Parameter MAX_BEATS, default 8: maximum number of beats accepted per frame.
REQ-002 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 RESET_L  input  1  reset, asynchronous assert, active-low.
REQ-004 IN_VALID  input  1  source asserts while DATA_IN, sc_sel, sc_EN and sc_LAST are stable.
REQ-005 IN_READY  output  1  block can accept a beat.
REQ-006 DATA_IN  input  32  beat payload; input lane i is bits [8i+7:8i], i=0..3.
REQ-007 sc_sel  input  12  lane i destination in field [3i+2:3i]: bit2 selects the bank (0 = A, 1 = B); bits1:0 give the destination byte position.
REQ-008 sc_EN  input  4  per-lane write enable; a disabled lane writes nothing.
REQ-009 sc_LAST  input  1  marks the final beat of a frame.
REQ-010 OUT_VALID, OUT_READY  output/input  1 each  frame handshake.
REQ-011 DATA_A, DATA_B  output  32 each  assembled bank words.
REQ-012 BYTE_EN_A, BYTE_EN_B  output  4 each  bytes written this frame.
REQ-013 ERR_COLLIDE, ERR_OVF  output  1 each  one-cycle error pulses.

Function
REQ-014 A beat is accepted on a CLK edge where IN_VALID=1 and IN_READY=1; there are no other acceptance conditions.
REQ-015 The state machine SHALL have three states:
- IDLE to ACCUM on an accepted beat without sc_LAST.
- IDLE or ACCUM to HOLD on an accepted beat with sc_LAST, or on the MAX_BEATS-th beat.
- HOLD to IDLE on the edge where OUT_READY=1.
REQ-016 IN_READY SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 Write rule: each enabled lane i writes DATA_IN lane i into its bank/byte and sets the matching BYTE_EN bit on the accepting edge.
REQ-018 Bytes that are not written SHALL keep their value.
REQ-019 A later beat overwriting an earlier-written byte wins silently.
REQ-020 Within-beat collision: if two or more enabled lanes target the same bank/byte, the highest lane index wins, and ERR_COLLIDE pulses high for exactly the cycle after acceptance.
REQ-021 OUT_VALID SHALL be 1 exactly while in HOLD, first asserted the cycle after the last beat is accepted.
REQ-022 DATA_A/B and BYTE_EN_A/B SHALL remain stable throughout HOLD.
REQ-023 Overflow: the MAX_BEATS-th accepted beat without sc_LAST is treated as last, and ERR_OVF pulses for one cycle.
REQ-024 Beat counter SHALL be clog2(MAX_BEATS)+1 bits, SHALL clear on HOLD exit, and SHALL NOT wrap.
REQ-025 On HOLD exit, DATA_A/B and BYTE_EN_A/B SHALL clear to 0 on the same edge.
REQ-026 IN_VALID during HOLD SHALL be ignored and SHALL NOT be accepted; the next frame's first beat can be accepted the cycle after the OUT_READY handshake.
REQ-027 A beat with sc_EN=0 is still accepted and counted, and its sc_LAST is honoured; if it closes the frame, the frame is emitted with all BYTE_EN bits 0.

Reset
REQ-028 RESET_L=0 SHALL immediately force:
- state IDLE, beat counter 0;
- DATA_A=DATA_B=0, BYTE_EN_A=BYTE_EN_B=0;
- OUT_VALID=0, ERR_COLLIDE=ERR_OVF=0;
- IN_READY=1 (IDLE value), combinationally after the state is forced.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial or pending frame with no output handshake.
REQ-030 Operation SHALL resume on the first CLK edge after RESET_L rises.

Structure
REQ-031 Package lane_scatter_pkg SHALL hold:
- state enum (IDLE, ACCUM, HOLD);
- LANES=4, SEL_W=3, BYTE_W=8.
REQ-032 One combinational sub-module lane_decode SHALL map sc_sel/sc_EN to per-bank byte write strobes, source-lane indices (priority to higher lanes) and the collision flag.

Verification
REQ-033 Single beat: DATA_IN=0x0000ABCD, lane0 to B pos0 (3'b100), lane1 to B pos1 (3'b101), sc_EN=0011, sc_LAST=1 -> next cycle OUT_VALID=1, DATA_B=0x0000ABCD, BYTE_EN_B=0011, DATA_A=0, BYTE_EN_A=0000.
REQ-034 Two beats: beat1 DATA_IN=0x00000FFF, lanes0,1 to A pos0,1; beat2 DATA_IN=0x11223344, lane3 to A pos3, sc_LAST=1 -> DATA_A=0x11000FFF, BYTE_EN_A=1011.
REQ-035 Collision: lanes0 and 2 both target A pos2, DATA_IN=0x00CC00AA, sc_EN=0101, sc_LAST=1 -> DATA_A=0x00CC0000, ERR_COLLIDE high for 1 cycle.
REQ-036 Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> IN_READY=0, outputs stable, no beat accepted; OUT_READY=1 -> next cycle IN_READY=1 and outputs clear.
REQ-037 Overflow: 8 beats without sc_LAST -> HOLD after the 8th, ERR_OVF pulse, and the 9th beat accepted only after the handshake.
REQ-038 Reset mid-frame: RESET_L=0 after 2 beats -> all outputs 0 and IN_READY=1 immediately; a fresh single-beat frame then completes correctly.
